// File: rtl/sram_responder_if.sv
// Address/control half of the external SRAM bus between the SRAM controller (master)
// and the SRAM device model (slave); the 64-bit data bus is a separate inout port.
interface sram_responder_if;
    logic [16:0] SRAM_ADDR;
    logic        SRAM_WE_N;
    logic        SRAM_CE_N;
    logic        SRAM_OE_N;
    logic        SRAM_UB_N;
    logic        SRAM_LB_N;

    modport master (
        output SRAM_ADDR, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N
    );

    modport slave (
        input SRAM_ADDR, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N
    );
endinterface

// File: rtl/sram_responder.sv
// Clocked model of the external 64-bit SRAM: fixed wait-state reads, lane-masked writes.
// Optional bus-violation checker enabled by defining SRAM_RESP_PROTOCOL_CHECK_EN.
//
// state    | meaning
// IDLE     | no access in progress, bus released
// RD_WAIT  | read accepted, counting wait states
// RD_DRIVE | read data available on SRAM_DQ (gated by OE_N/CE_N/lane enables)
// WR_WAIT  | write accepted, counting wait states before commit
// WR_DONE  | write committed, waiting for WE_N or CE_N to rise
module sram_responder #(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_STATES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    sram_responder_if.slave       bus,
    // Kept as a plain inout so the tristate resolves at the instantiating level.
    inout  wire  [63:0]           SRAM_DQ,
    output logic [15:0]           rd_count,
    output logic [15:0]           wr_count,
    output logic                  protocol_err
);
    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_DRIVE,
        WR_WAIT,
        WR_DONE
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_STATES - 1);

    state_t      state_q, state_d;
    logic [16:0] addr_q, addr_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        rd_inc;
    logic        wr_commit;

    logic        ce_n, we_n, oe_n, ub_n, lb_n;
    logic [16:0] addr;
    logic        addr_changed;

    logic [63:0] mem [2**DEPTH_LOG2];
    logic [63:0] rd_data;
    logic        drive_base, oe_hi, oe_lo;

    assign ce_n         = bus.SRAM_CE_N;
    assign we_n         = bus.SRAM_WE_N;
    assign oe_n         = bus.SRAM_OE_N;
    assign ub_n         = bus.SRAM_UB_N;
    assign lb_n         = bus.SRAM_LB_N;
    assign addr         = bus.SRAM_ADDR;
    assign addr_changed = (addr != addr_q);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        rd_inc    = 1'b0;
        wr_commit = 1'b0;
        case (state_q)
            IDLE: begin
                if (!ce_n && !we_n) begin
                    addr_d  = addr;
                    cnt_d   = CNT_LOAD;
                    state_d = WR_WAIT;
                end else if (!ce_n && !oe_n) begin
                    addr_d  = addr;
                    cnt_d   = CNT_LOAD;
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (ce_n || !we_n) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd0) begin
                    rd_inc  = 1'b1;
                    state_d = RD_DRIVE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RD_DRIVE: begin
                if (ce_n || !we_n) begin
                    state_d = IDLE;
                end else if (addr_changed) begin
                    addr_d  = addr;
                    cnt_d   = CNT_LOAD;
                    state_d = RD_WAIT;
                end
            end
            WR_WAIT: begin
                // An address change restarts the wait window and wins over the commit.
                if (ce_n || we_n) begin
                    state_d = IDLE;
                end else if (addr_changed) begin
                    addr_d = addr;
                    cnt_d  = CNT_LOAD;
                end else if (cnt_q == 4'd0) begin
                    wr_commit = 1'b1;
                    state_d   = WR_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WR_DONE: begin
                if (ce_n || we_n) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            rd_count <= rd_count + 16'(rd_inc);
            wr_count <= wr_count + 16'(wr_commit);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_commit && !rst) begin
            if (!ub_n) mem[addr_q[DEPTH_LOG2-1:0]][63:32] <= SRAM_DQ[63:32];
            if (!lb_n) mem[addr_q[DEPTH_LOG2-1:0]][31:0]  <= SRAM_DQ[31:0];
        end
    end

    assign rd_data    = mem[addr_q[DEPTH_LOG2-1:0]];
    assign drive_base = (state_q == RD_DRIVE) && !oe_n && !ce_n;
    assign oe_hi      = drive_base && !ub_n;
    assign oe_lo      = drive_base && !lb_n;

    assign SRAM_DQ[63:32] = oe_hi ? rd_data[63:32] : 32'bz;
    assign SRAM_DQ[31:0]  = oe_lo ? rd_data[31:0]  : 32'bz;

`ifdef SRAM_RESP_PROTOCOL_CHECK_EN
    logic [16:0] addr_prev;
    logic [63:0] dq_prev;
    logic        perr_q;
    logic        violation;

    assign violation = (!ce_n && !we_n && !oe_n) ||
                       ((state_q == WR_WAIT) && ((addr != addr_prev) || (SRAM_DQ != dq_prev)));

    always_ff @(posedge clk) begin
        addr_prev <= addr;
        dq_prev   <= SRAM_DQ;
        if (rst) begin
            perr_q <= 1'b0;
        end else if (violation) begin
            perr_q <= 1'b1;
`ifndef SYNTHESIS
            $display("sram_responder: protocol violation at address %h", addr);
`endif
        end
    end

    assign protocol_err = perr_q;
`else
    assign protocol_err = 1'b0;
`endif
endmodule

// File: doc/sram_responder.md
# sram_responder

Synthesizable clocked model of the external 64-bit SRAM device on the memory-stage SRAM bus. It is the responder end of the `SRAM_ADDR`/`SRAM_DQ`/`SRAM_*_N` interface driven by the SRAM controller. It stores data in an internal array, returns reads after a fixed number of wait states, and commits lane-masked writes. It lets the processor core and memory stage run in simulation and on FPGA without the board SRAM.

## Interface
Parameters:
- `DEPTH_LOG2`, 10, internal array holds 2^DEPTH_LOG2 64-bit words, indexed by `SRAM_ADDR[DEPTH_LOG2-1:0]`; upper address bits are ignored (aliasing).
- `WAIT_STATES`, 4, cycles from request detection to read data driven or write commit; legal range 1..15.

Ports:
- `clk`  input  1  sole clock; everything samples on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `SRAM_ADDR`  input  17  word address.
- `SRAM_WE_N`  input  1  write enable, active low.
- `SRAM_CE_N`  input  1  chip enable, active low.
- `SRAM_OE_N`  input  1  output enable, active low.
- `SRAM_UB_N`  input  1  upper lane enable, bits [63:32], active low.
- `SRAM_LB_N`  input  1  lower lane enable, bits [31:0], active low.
- `SRAM_DQ`  inout  64  bidirectional data.
- `rd_count`  output  16  completed reads, wraps at 16'hFFFF.
- `wr_count`  output  16  committed writes, wraps at 16'hFFFF.
- `protocol_err`  output  1  sticky bus-violation flag (see Configuration).

## Operation
- States: `IDLE`, `RD_WAIT`, `RD_DRIVE`, `WR_WAIT`, `WR_DONE`. The internal wait counter is 4 bits.
- `IDLE`:
  - Sampled `CE_N=0`, `WE_N=1`, `OE_N=0` → latch `addr_q`, load the counter, go to `RD_WAIT`.
  - Sampled `CE_N=0`, `WE_N=0` → latch `addr_q`, load the counter, go to `WR_WAIT`.
  - Otherwise stay in `IDLE`.
- `RD_WAIT`: decrement each cycle. At terminal count go to `RD_DRIVE` and increment `rd_count` once.
- `RD_DRIVE`: drive `mem[addr_q]` on `SRAM_DQ` while `CE_N=0` and `OE_N=0`.
  - A lane is driven only if its `*B_N` is 0; a disabled lane is high-Z.
  - If `SRAM_ADDR` differs from `addr_q`: re-latch, reload the counter, go to `RD_WAIT`.
- `WR_WAIT`: decrement each cycle.
  - At terminal count, write the enabled lanes of `SRAM_DQ` into `mem[addr_q]`, increment `wr_count`, go to `WR_DONE`.
  - If the address changes: re-latch and reload the counter, with no commit.
- `WR_DONE`: hold with no further commit until `WE_N=1` or `CE_N=1`, then go to `IDLE`. This prevents double-commit.
- From any non-`IDLE` state, sampled `CE_N=1` → `IDLE` with no commit.
- In `RD_*` states, sampled `WE_N=0` → abort to `IDLE`, no read counted.
- In `WR_WAIT`, sampled `WE_N=1` → abort to `IDLE`, no commit.
- If both `UB_N` and `LB_N` are 1, the cycle runs to completion and is counted; no lanes are written and nothing is driven.
- The memory array is not reset; its contents are unspecified until written.

## Timing
- Reset values: state `IDLE`, `SRAM_DQ` all high-Z, `rd_count`=0, `wr_count`=0, `protocol_err`=0.
- Reset mid-operation: the access is abandoned, no commit, and the bus is released in the same cycle `rst` is sampled high.
- The `SRAM_DQ` output enable is combinational from (state==`RD_DRIVE`) & ~`OE_N` & ~`CE_N` & lane enable. Raising `OE_N` or `CE_N` releases the bus in the same cycle, so there is no contention when the controller turns the bus around.
- Read latency: request sampled at edge 0 → data valid after edge `WAIT_STATES`.
- Write latency: request sampled at edge 0 → commit at edge `WAIT_STATES`, using DQ as sampled at that edge. The controller must hold `ADDR`/`DQ`/`WE_N` stable across this window.
- A read of an address committed at edge N returns the new data if it is issued at edge N+1 or later.

## Configuration
- `SRAM_RESP_PROTOCOL_CHECK_EN` defined:
  - `protocol_err` sets on any edge sampling `CE_N=0`, `WE_N=0`, `OE_N=0`.
  - It also sets if `SRAM_ADDR` or `SRAM_DQ` changes during `WR_WAIT`.
  - It clears only on `rst`.
  - Under simulation, each set also issues a `$display` with the address.
- Not defined: `protocol_err` is tied to 0, no check logic is generated, and all other behaviour is identical.

## Test plan
- Write then read, `WAIT_STATES`=4: write 64'h1122_3344_5566_7788 to address 17'h0005 with both lanes enabled, then read 17'h0005 → DQ equals that value from edge 4 of the read; `wr_count`=1, `rd_count`=1.
- Lane mask: write 64'hFFFF_FFFF_FFFF_FFFF with `UB_N`=1 over an address holding 64'hAAAA_AAAA_BBBB_BBBB → a read returns 64'hAAAA_AAAA_FFFF_FFFF. A read with `LB_N`=1 leaves [31:0] high-Z.
- Write abort: raise `WE_N` at edge 2 of a write to address 17'h0010 holding 64'h0 → the word stays 0 and `wr_count` is unchanged.
- Long write hold: hold `WE_N`=0 for 12 cycles → exactly one commit and `wr_count`+1.
- Reset mid-read: assert `rst` in `RD_WAIT` → DQ high-Z, counters 0, state `IDLE`. A following read to the same address completes normally.
- Macro defined: drive `CE_N`=`WE_N`=`OE_N`=0 for one cycle → `protocol_err`=1 and stays 1 until `rst`. Macro undefined, same stimulus → `protocol_err` stays 0.
